// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared state codes, opcodes and control-field encodings for the VA7 sequencer
package instr_sequencer_pkg;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_FETCH  = 3'd1;
   localparam state_t S_DECODE = 3'd2;
   localparam state_t S_EXEC   = 3'd3;
   localparam state_t S_MEM    = 3'd4;
   localparam state_t S_WB     = 3'd5;
   localparam state_t S_HALTED = 3'd6;
   localparam state_t S_FAULT  = 3'd7;
   localparam logic [5:0] OP_ALUR = 6'h00;
   localparam logic [5:0] OP_ALUI = 6'h01;
   localparam logic [5:0] OP_LD   = 6'h02;
   localparam logic [5:0] OP_ST   = 6'h03;
   localparam logic [5:0] OP_BR   = 6'h04;
   localparam logic [5:0] OP_BPL  = 6'h05;
   localparam logic [5:0] OP_BMI  = 6'h06;
   localparam logic [5:0] OP_BZ   = 6'h07;
   localparam logic [5:0] OP_PUSH = 6'h08;
   localparam logic [5:0] OP_POP  = 6'h09;
   localparam logic [5:0] OP_CALL = 6'h0A;
   localparam logic [5:0] OP_RET  = 6'h0B;
   localparam logic [5:0] OP_HALT = 6'h3F;
   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BR   = 3'b001;
   localparam logic [2:0] BR_BPL  = 3'b010;
   localparam logic [2:0] BR_BMI  = 3'b011;
   localparam logic [2:0] BR_BZ   = 3'b100;
   localparam logic [2:0] SK_NONE = 3'b000;
   localparam logic [2:0] SK_PUSH = 3'b001;
   localparam logic [2:0] SK_POP  = 3'b010;
   localparam logic [2:0] SK_CALL = 3'b011;
   localparam logic [2:0] SK_RET  = 3'b100;
   localparam logic [1:0] ADDR_PC  = 2'd0;
   localparam logic [1:0] ADDR_ALU = 2'd1;
   localparam logic [1:0] ADDR_SP  = 2'd2;
endpackage

// File: rtl/instr_sequencer_opcode_decoder.sv
// instr_sequencer_opcode_decoder: combinational opcode to control-field map; unknown opcodes decode as a NOP
module instr_sequencer_opcode_decoder
   import instr_sequencer_pkg::*;
(
   input  logic [5:0] opcode,
   output logic       needs_mem,
   output logic       mem_write,
   output logic [1:0] addr_sel,
   output logic       reg_we,
   output logic       sp_we,
   output logic [2:0] branch_op,
   output logic [2:0] stack_op,
   output logic       is_halt
);
   // decode every control field from the opcode alone
   always_comb begin
      needs_mem = 1'b0;
      mem_write = 1'b0;
      addr_sel  = ADDR_PC;
      reg_we    = 1'b0;
      sp_we     = 1'b0;
      branch_op = BR_NONE;
      stack_op  = SK_NONE;
      is_halt   = 1'b0;
      case (opcode)
         OP_ALUR, OP_ALUI: reg_we = 1'b1;
         OP_LD:   begin needs_mem = 1'b1; addr_sel = ADDR_ALU; reg_we = 1'b1; end
         OP_ST:   begin needs_mem = 1'b1; addr_sel = ADDR_ALU; mem_write = 1'b1; end
         OP_BR:   branch_op = BR_BR;
         OP_BPL:  branch_op = BR_BPL;
         OP_BMI:  branch_op = BR_BMI;
         OP_BZ:   branch_op = BR_BZ;
         OP_PUSH: begin needs_mem = 1'b1; addr_sel = ADDR_SP; mem_write = 1'b1; sp_we = 1'b1; stack_op = SK_PUSH; end
         OP_POP:  begin needs_mem = 1'b1; addr_sel = ADDR_SP; reg_we = 1'b1; sp_we = 1'b1; stack_op = SK_POP; end
         OP_CALL: begin needs_mem = 1'b1; addr_sel = ADDR_SP; mem_write = 1'b1; sp_we = 1'b1; stack_op = SK_CALL; end
         OP_RET:  begin needs_mem = 1'b1; addr_sel = ADDR_SP; sp_we = 1'b1; stack_op = SK_RET; end
         OP_HALT: is_halt = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout and retire counter
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      instr,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic [1:0]       addr_sel,
   output logic             ir_we,
   output logic             alu_en,
   output logic             reg_we,
   output logic             sp_we,
   output logic             pc_we,
   output logic [2:0]       branch_op,
   output logic [2:0]       stack_op,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   state_t        state, nxt;
   logic [TW-1:0] cnt;
   logic          d_mem, d_wr, d_reg, d_sp, d_halt;
   logic [1:0]    d_addr;
   logic [2:0]    d_br, d_sk;
   logic          waiting, timeout;
   logic          unused_instr;
   assign unused_instr = ^instr[25:0];
   instr_sequencer_opcode_decoder u_dec (
      .opcode    (instr[31:26]),
      .needs_mem (d_mem),
      .mem_write (d_wr),
      .addr_sel  (d_addr),
      .reg_we    (d_reg),
      .sp_we     (d_sp),
      .branch_op (d_br),
      .stack_op  (d_sk),
      .is_halt   (d_halt)
   );
   assign mem_req   = state == S_FETCH || state == S_MEM;
   assign mem_we    = state == S_MEM && d_wr;
   assign addr_sel  = state == S_MEM ? d_addr : ADDR_PC;
   assign ir_we     = state == S_FETCH && mem_ready;
   assign alu_en    = state == S_EXEC;
   assign reg_we    = state == S_WB && d_reg;
   assign sp_we     = state == S_WB && d_sp;
   assign pc_we     = state == S_WB;
   assign branch_op = state == S_WB ? d_br : BR_NONE;
   assign stack_op  = state == S_WB ? d_sk : SK_NONE;
   assign halted    = state == S_HALTED;
   assign fault     = state == S_FAULT;
   assign waiting   = mem_req && !mem_ready;
   assign timeout   = waiting && cnt == TW'(MEM_TIMEOUT - 1);
   // next state; the access that would push the wait count to MEM_TIMEOUT goes to FAULT instead
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   nxt = start ? S_FETCH : S_IDLE;
         S_FETCH:  nxt = mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
         S_DECODE: nxt = d_halt ? S_HALTED : S_EXEC;
         S_EXEC:   nxt = d_mem ? S_MEM : S_WB;
         S_MEM:    nxt = mem_ready ? S_WB : timeout ? S_FAULT : S_MEM;
         S_WB:     nxt = S_FETCH;
         default:  nxt = state;
      endcase
   end
   // state, wait counter and retired-instruction counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         retired <= '0;
      end else begin
         state   <= nxt;
         cnt     <= waiting ? cnt + TW'(1) : mem_req ? '0 : cnt;
         retired <= state == S_WB ? retired + CNT_W'(1) : retired;
      end
   end
endmodule
